drive_cmd_scheduler: RTL and testbench
======================================

DRIVE_CMD_SCHEDULER -- requirements
Module: drive_cmd_scheduler

Interface
- REQ-001 The block SHALL have these parameters:
  - CLK_HZ, default 50_000_000: input clock frequency.
  - RESEND_MS, default 200: periodic re-send interval for an unchanged command.
  - HOLD_MS, default 500: window after an IR command during which camera input is ignored.
  - TIMEOUT_MS, default 20: maximum wait for tx_ack.
- REQ-002 The block SHALL have these ports:
  - clk_50  in  1: sole clock.
  - reset  in  1: asynchronous, active-high reset.
  - ir_valid  in  1: one-cycle strobe, new IR command.
  - ir_cmd  in  4: IR drive command, drive_cmd_t encoding.
  - cam_valid  in  1: one-cycle strobe, camera result updated (once per frame).
  - cam_direction  in  3: one-hot; 001 left, 010 centre, 100 right.
  - orange_detected  in  1: target present in frame.
  - speed  in  2: audio speed class; 0 slow, 1 medium, 2 fast, 3 treated as fast.
  - tx_req  out  1: command request to UART JSON sender.
  - tx_cmd  out  4: command presented with tx_req.
  - tx_speed  out  2: speed presented with tx_req.
  - tx_ack  in  1: one-cycle strobe, sender accepted/finished command.
  - source  out  2: 0 none, 1 IR, 2 camera.
  - timeout_err  out  1: one-cycle pulse on ack timeout.

Function
- REQ-003 drive_cmd_t SHALL encode STOP=0, FWD=1, LEFT=2, RIGHT=3, REV=4; any other value SHALL be treated as STOP.
- REQ-004 Camera mapping SHALL be:
  - orange_detected=0 -> STOP.
  - 001 -> LEFT; 010 -> FWD; 100 -> RIGHT.
  - Any non-one-hot direction -> STOP.
- REQ-005 Arbitration priority SHALL be IR over camera over STOP.
  - An ir_valid SHALL load the IR command and restart the hold counter of HOLD_MS*CLK_HZ/1000 cycles.
  - cam_valid SHALL be ignored while the hold counter is nonzero.
  - If ir_valid and cam_valid occur in the same cycle, IR SHALL win.
- REQ-006 The FSM states SHALL be IDLE, ARB, SEND and WAIT_ACK.
  - IDLE -> ARB on ir_valid, on an accepted cam_valid, or on resend-timer expiry.
  - ARB -> SEND when the selected {cmd, speed} differs from the last sent pair, or on resend expiry; otherwise ARB -> IDLE.
  - SEND raises tx_req, then moves to WAIT_ACK.
  - WAIT_ACK -> IDLE on tx_ack.
- REQ-007 tx_cmd and tx_speed SHALL be registered in ARB and held stable while tx_req=1.
- REQ-008 tx_req SHALL stay high from SEND until the cycle after tx_ack; an ack with tx_req low SHALL be ignored.
- REQ-009 The latency from ir_valid to tx_req=1 SHALL be 3 cycles when the FSM is in IDLE.
- REQ-010 New inputs arriving during SEND/WAIT_ACK SHALL be latched (latest wins) and processed on return to IDLE.
- REQ-011 The resend timer (RESEND_MS) SHALL restart on each tx_ack and expire to force re-send of the last command.
- REQ-012 Hold expiry SHALL NOT by itself change the command; the next cam_valid SHALL.
- REQ-013 Timer counters SHALL saturate at zero and never wrap.

Reset
- REQ-014 On reset:
  - state=IDLE; tx_req=0; tx_cmd=STOP; tx_speed=0; source=0; timeout_err=0.
  - Hold and resend counters cleared; last-sent pair = {STOP,0}.
- REQ-015 Reset asserted during WAIT_ACK SHALL drop tx_req immediately (asynchronously); a later tx_ack SHALL be ignored.
- REQ-016 The first command after reset release SHALL be sent only when it differs from STOP/0 or on resend expiry.

Configuration
- REQ-017 With macro DRIVE_SCHED_WATCHDOG_EN defined, a WAIT_ACK longer than TIMEOUT_MS SHALL:
  - drop tx_req;
  - pulse timeout_err for one cycle;
  - return to IDLE with the last-sent pair invalidated, forcing a re-send.
- REQ-018 Without DRIVE_SCHED_WATCHDOG_EN, WAIT_ACK SHALL wait indefinitely and timeout_err SHALL be tied 0.

Structure
- REQ-019 Package drive_pkg SHALL hold drive_cmd_t, the source enum, the FSM state typedef and the camera direction constants.
- REQ-020 One sub-module, ms_countdown, SHALL be instantiated for the hold, resend and timeout timers: load, tick and zero flag.

Verification
- REQ-021 The bench SHALL cover these directed scenarios:
  - ir_valid with ir_cmd=FWD, speed=2 -> tx_req high 3 cycles later, tx_cmd=1, tx_speed=2, source=1; ack -> IDLE.
  - IR LEFT, then cam_valid with direction 100 100 ms later -> no request; same cam_valid at 600 ms -> tx_cmd=RIGHT, source=2.
  - Same-cycle ir_valid(REV) and cam_valid(010) -> tx_cmd=4.
  - Unchanged camera FWD for 450 ms with prompt acks -> exactly 2 re-sends, at 200 ms and 400 ms.
  - DRIVE_SCHED_WATCHDOG_EN defined, tx_ack withheld -> tx_req low and timeout_err pulse at 20 ms, re-send follows.
  - Reset asserted mid-WAIT_ACK -> tx_req=0 immediately; tx_cmd=STOP after release.

Source files
------------

// File: rtl/drive_pkg.sv
// Shared types for the drive command scheduler: command/source/state enums,
// camera direction codes and input normalisation helpers.
package drive_pkg;

  typedef enum logic [3:0] {
    CMD_STOP  = 4'd0,
    CMD_FWD   = 4'd1,
    CMD_LEFT  = 4'd2,
    CMD_RIGHT = 4'd3,
    CMD_REV   = 4'd4
  } drive_cmd_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IR   = 2'd1,
    SRC_CAM  = 2'd2
  } source_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_SEND,
    S_WAIT_ACK
  } state_t;

  typedef struct packed {
    drive_cmd_t cmd;
    logic [1:0] speed;
  } drive_pair_t;

  localparam logic [2:0] DIR_LEFT   = 3'b001;
  localparam logic [2:0] DIR_CENTRE = 3'b010;
  localparam logic [2:0] DIR_RIGHT  = 3'b100;

  // Unknown IR codes collapse to STOP so a corrupted remote frame halts the robot.
  function automatic drive_cmd_t norm_cmd(input logic [3:0] c);
    case (c)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: norm_cmd = drive_cmd_t'(c);
      default:                      norm_cmd = CMD_STOP;
    endcase
  endfunction

  function automatic drive_cmd_t cam_to_cmd(input logic orange, input logic [2:0] dir);
    if (!orange) cam_to_cmd = CMD_STOP;
    else begin
      case (dir)
        DIR_LEFT:   cam_to_cmd = CMD_LEFT;
        DIR_CENTRE: cam_to_cmd = CMD_FWD;
        DIR_RIGHT:  cam_to_cmd = CMD_RIGHT;
        default:    cam_to_cmd = CMD_STOP;
      endcase
    end
  endfunction

  function automatic logic [1:0] norm_speed(input logic [1:0] s);
    norm_speed = (s == 2'd3) ? 2'd2 : s;
  endfunction

endpackage

// File: rtl/ms_countdown.sv
// Loadable down-counter in clock cycles; saturates at zero. 'expire' is a
// combinational strobe on the tick that takes the count from 1 to 0.
module ms_countdown #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        count <= '0;
    else if (load)                  count <= load_val;
    else if (tick && count != '0)   count <= count - 1'b1;
  end

  assign zero   = (count == '0);
  assign expire = tick && !load && (count == W'(1));

endmodule

// File: rtl/drive_cmd_scheduler.sv
// Arbitrates IR and camera drive commands and hands them to the UART sender.
// Define DRIVE_SCHED_WATCHDOG_EN to enable the tx_ack timeout watchdog.
module drive_cmd_scheduler
  import drive_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int RESEND_MS  = 200,
  parameter int HOLD_MS    = 500,
  parameter int TIMEOUT_MS = 20
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       ir_valid,
  input  logic [3:0] ir_cmd,
  input  logic       cam_valid,
  input  logic [2:0] cam_direction,
  input  logic       orange_detected,
  input  logic [1:0] speed,
  output logic       tx_req,
  output logic [3:0] tx_cmd,
  output logic [1:0] tx_speed,
  input  logic       tx_ack,
  output logic [1:0] source,
  output logic       timeout_err
);

  localparam int CW = 32;
  // Products are formed in 64 bits; HOLD_MS*CLK_HZ overflows a 32-bit int.
  localparam longint HOLD_L   = longint'(HOLD_MS)   * longint'(CLK_HZ) / 1000;
  localparam longint RESEND_L = longint'(RESEND_MS) * longint'(CLK_HZ) / 1000;
  localparam logic [CW-1:0] HOLD_CYC   = HOLD_L[CW-1:0];
  localparam logic [CW-1:0] RESEND_CYC = RESEND_L[CW-1:0];

  state_t      state;
  drive_cmd_t  sel_cmd;
  source_t     sel_src;
  drive_pair_t last;
  logic        last_valid;
  logic        pend, resend_pend;
  logic        hold_zero, hold_exp, rs_zero, resend_exp;
  logic        cam_ok, new_evt, do_send;
  drive_pair_t cur_pair;

  assign cam_ok   = cam_valid && hold_zero && !ir_valid;
  assign new_evt  = ir_valid || cam_ok;
  assign cur_pair = '{cmd: sel_cmd, speed: norm_speed(speed)};
  assign do_send  = (cur_pair != last) || !last_valid || resend_pend;

  ms_countdown #(.W(CW)) u_hold (
    .clk(clk_50), .rst(reset), .load(ir_valid), .load_val(HOLD_CYC),
    .tick(1'b1), .zero(hold_zero), .expire(hold_exp)
  );

  ms_countdown #(.W(CW)) u_resend (
    .clk(clk_50), .rst(reset), .load(state == S_WAIT_ACK && tx_ack),
    .load_val(RESEND_CYC), .tick(1'b1), .zero(rs_zero), .expire(resend_exp)
  );

  logic unused;
  assign unused = ^{hold_exp, rs_zero};

`ifdef DRIVE_SCHED_WATCHDOG_EN
  localparam longint TO_L = longint'(TIMEOUT_MS) * longint'(CLK_HZ) / 1000;
  localparam logic [CW-1:0] TO_CYC = TO_L[CW-1:0];
  logic to_zero, to_exp, to_err_q;

  ms_countdown #(.W(CW)) u_timeout (
    .clk(clk_50), .rst(reset), .load(state == S_SEND), .load_val(TO_CYC),
    .tick(state == S_WAIT_ACK), .zero(to_zero), .expire(to_exp)
  );
  assign timeout_err = to_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      tx_req      <= 1'b0;
      tx_cmd      <= CMD_STOP;
      tx_speed    <= 2'd0;
      source      <= SRC_NONE;
      sel_cmd     <= CMD_STOP;
      sel_src     <= SRC_NONE;
      last        <= '{cmd: CMD_STOP, speed: 2'd0};
      last_valid  <= 1'b1;
      pend        <= 1'b0;
      resend_pend <= 1'b0;
`ifdef DRIVE_SCHED_WATCHDOG_EN
      to_err_q    <= 1'b0;
`endif
    end else begin
`ifdef DRIVE_SCHED_WATCHDOG_EN
      to_err_q <= 1'b0;
`endif
      // The selection tracks the latest event in every state; busy states just defer it.
      if (ir_valid) begin
        sel_cmd <= norm_cmd(ir_cmd);
        sel_src <= SRC_IR;
      end else if (cam_ok) begin
        sel_cmd <= cam_to_cmd(orange_detected, cam_direction);
        sel_src <= SRC_CAM;
      end
      if (new_evt)    pend        <= 1'b1;
      if (resend_exp) resend_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (pend || new_evt || resend_pend || resend_exp) begin
            state <= S_ARB;
            pend  <= 1'b0;
          end
        end
        S_ARB: begin
          resend_pend <= resend_exp && !do_send;
          if (do_send) begin
            tx_cmd     <= cur_pair.cmd;
            tx_speed   <= cur_pair.speed;
            source     <= sel_src;
            last       <= cur_pair;
            last_valid <= 1'b1;
            state      <= S_SEND;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SEND: begin
          tx_req <= 1'b1;
          state  <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (tx_ack) begin
            tx_req <= 1'b0;
            state  <= S_IDLE;
          end
`ifdef DRIVE_SCHED_WATCHDOG_EN
          else if (to_exp) begin
            // Unacknowledged command is treated as lost and re-sent from IDLE.
            tx_req     <= 1'b0;
            to_err_q   <= 1'b1;
            last_valid <= 1'b0;
            pend       <= 1'b1;
            state      <= S_IDLE;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drive_cmd_scheduler.sv
// Directed bench for drive_cmd_scheduler; scaled to 1 cycle per ms (CLK_HZ=1000).
module tb_drive_cmd_scheduler;

  logic       clk_50 = 1'b0;
  logic       reset, ir_valid, cam_valid, orange_detected, tx_ack;
  logic [3:0] ir_cmd, tx_cmd;
  logic [2:0] cam_direction;
  logic [1:0] speed, tx_speed, source;
  logic       tx_req, timeout_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int terr_cnt = 0;
  logic ack_en = 1'b1;
  logic manual_ack = 1'b0;
  logic prev_req = 1'b0;

  typedef struct {
    logic [3:0] cmd;
    logic [1:0] spd;
    logic [1:0] src;
    int         t;
  } rec_t;

  rec_t obs_q[$];
  rec_t exp_q[$];

  drive_cmd_scheduler #(.CLK_HZ(1000), .RESEND_MS(200), .HOLD_MS(500), .TIMEOUT_MS(20)) dut (
    .clk_50(clk_50), .reset(reset), .ir_valid(ir_valid), .ir_cmd(ir_cmd),
    .cam_valid(cam_valid), .cam_direction(cam_direction), .orange_detected(orange_detected),
    .speed(speed), .tx_req(tx_req), .tx_cmd(tx_cmd), .tx_speed(tx_speed), .tx_ack(tx_ack),
    .source(source), .timeout_err(timeout_err)
  );

  always #5 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc++;

  always @(negedge clk_50) begin
    if (tx_req && !prev_req) obs_q.push_back('{tx_cmd, tx_speed, source, cyc});
    prev_req = tx_req;
    if (timeout_err) terr_cnt++;
  end

  // Sender model: acks a pending request one cycle after it appears.
  always @(posedge clk_50) begin
    #1;
    tx_ack = (ack_en && tx_req && !tx_ack) || manual_ack;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ir_valid = 0; cam_valid = 0; ir_cmd = 0; cam_direction = 0;
    orange_detected = 0; speed = 0; ack_en = 1'b1; manual_ack = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    obs_q.delete(); exp_q.delete(); terr_cnt = 0;
  endtask

  task automatic ir_pulse(input logic [3:0] c, input logic [1:0] s);
    ir_valid = 1'b1; ir_cmd = c; speed = s;
    tick(1);
    ir_valid = 1'b0;
  endtask

  task automatic cam_pulse(input logic [2:0] d, input logic o, input logic [1:0] s);
    cam_valid = 1'b1; cam_direction = d; orange_detected = o; speed = s;
    tick(1);
    cam_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin tick(1); k++; end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1; ir_valid = 0; cam_valid = 0; ir_cmd = 0; cam_direction = 0;
    orange_detected = 0; speed = 0;
    tick(2);
    checks++;
    if ({tx_req, tx_cmd, tx_speed, source, timeout_err} !== 10'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %0h expected 0", {tx_req, tx_cmd, tx_speed, source, timeout_err});
    end
    reset = 1'b0;
    tick(2);
    obs_q.delete();
    ir_pulse(4'd0, 2'd0);
    tick(3);
    ir_pulse(4'd9, 2'd0);
    tick(10);
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL reset_first_stop_no_send: got %0d requests expected 0", obs_q.size());
    end
  endtask

  task automatic test_ir_latency();
    bit ok;
    rec_t e, o;
    do_reset();
    ir_pulse(4'd1, 2'd2);
    exp_q.push_back('{4'd1, 2'd2, 2'd1, 0});
    tick(1);
    checks++;
    if (tx_req !== 1'b0) begin failures++; $display("FAIL ir_latency_early: got %b expected 0", tx_req); end
    tick(1);
    checks++;
    if (tx_req !== 1'b1) begin failures++; $display("FAIL ir_latency_3cyc: got %b expected 1", tx_req); end
    wait_obs(1, 10, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL ir_request_seen: got 0 requests expected 1");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if ({o.cmd, o.spd, o.src} !== {e.cmd, e.spd, e.src}) begin
        failures++;
        $display("FAIL ir_request: got cmd=%0d spd=%0d src=%0d expected cmd=%0d spd=%0d src=%0d",
                 o.cmd, o.spd, o.src, e.cmd, e.spd, e.src);
      end
    end
    tick(3);
    checks++;
    if (tx_req !== 1'b0) begin failures++; $display("FAIL ir_ack_release: got %b expected 0", tx_req); end
  endtask

  task automatic test_hold();
    bit ok;
    int t0;
    rec_t e, o;
    do_reset();
    t0 = cyc;
    ir_pulse(4'd2, 2'd1);
    exp_q.push_back('{4'd2, 2'd1, 2'd1, 0});
    wait_obs(1, 10, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL hold_ir_seen: got 0 requests expected 1");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if ({o.cmd, o.src} !== {e.cmd, e.src}) begin
        failures++; $display("FAIL hold_ir_cmd: got cmd=%0d src=%0d expected cmd=%0d src=%0d", o.cmd, o.src, e.cmd, e.src);
      end
    end
    tick(100 - (cyc - t0));
    obs_q.delete();
    cam_pulse(3'b100, 1'b1, 2'd1);
    tick(20);
    checks++;
    if (obs_q.size() != 0 || tx_cmd !== 4'd2) begin
      failures++; $display("FAIL hold_cam_ignored: got %0d requests cmd=%0d expected 0 requests cmd=2", obs_q.size(), tx_cmd);
    end
    tick(600 - (cyc - t0));
    obs_q.delete();
    cam_pulse(3'b100, 1'b1, 2'd1);
    exp_q.push_back('{4'd3, 2'd1, 2'd2, 0});
    tick(15);
    checks++;
    if (obs_q.size() == 0) begin
      failures++; $display("FAIL hold_cam_after: got 0 requests expected 1");
    end else begin
      e = exp_q.pop_front(); o = obs_q[$];
      if ({o.cmd, o.src} !== {e.cmd, e.src}) begin
        failures++; $display("FAIL hold_cam_after: got cmd=%0d src=%0d expected cmd=%0d src=%0d", o.cmd, o.src, e.cmd, e.src);
      end
    end
  endtask

  task automatic test_same_cycle();
    bit ok;
    rec_t e, o;
    do_reset();
    ir_valid = 1'b1; ir_cmd = 4'd4; cam_valid = 1'b1; cam_direction = 3'b010;
    orange_detected = 1'b1; speed = 2'd0;
    tick(1);
    ir_valid = 1'b0; cam_valid = 1'b0;
    exp_q.push_back('{4'd4, 2'd0, 2'd1, 0});
    wait_obs(1, 10, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL same_cycle_seen: got 0 requests expected 1");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if ({o.cmd, o.src} !== {e.cmd, e.src}) begin
        failures++; $display("FAIL same_cycle_ir_wins: got cmd=%0d src=%0d expected cmd=%0d src=%0d", o.cmd, o.src, e.cmd, e.src);
      end
    end
  endtask

  task automatic test_cam_map();
    // {direction, orange, speed, expected cmd, expected speed, request expected}
    logic [2:0] dir_t [7] = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b110, 3'b000, 3'b100};
    logic       org_t [7] = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1};
    logic [1:0] spd_t [7] = '{2'd0,   2'd0,   2'd2,   2'd3,   2'd2,   2'd2,   2'd1};
    logic [3:0] cmd_t [7] = '{4'd2,   4'd0,   4'd1,   4'd1,   4'd0,   4'd0,   4'd3};
    logic [1:0] esp_t [7] = '{2'd0,   2'd0,   2'd2,   2'd2,   2'd2,   2'd2,   2'd1};
    logic       req_t [7] = '{1'b1,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1};
    rec_t e, o;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      obs_q.delete();
      cam_pulse(dir_t[i], org_t[i], spd_t[i]);
      if (req_t[i]) exp_q.push_back('{cmd_t[i], esp_t[i], 2'd2, 0});
      tick(10);
      checks++;
      if (obs_q.size() != (req_t[i] ? 1 : 0)) begin
        failures++; $display("FAIL cam_map_count[%0d]: got %0d requests expected %0d", i, obs_q.size(), req_t[i]);
      end else if (req_t[i]) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if ({o.cmd, o.spd, o.src} !== {e.cmd, e.spd, e.src}) begin
          failures++;
          $display("FAIL cam_map[%0d]: got cmd=%0d spd=%0d src=%0d expected cmd=%0d spd=%0d src=%0d",
                   i, o.cmd, o.spd, o.src, e.cmd, e.spd, e.src);
        end
      end
    end
  endtask

  task automatic test_resend();
    int d1, d2;
    do_reset();
    for (int i = 0; i < 3; i++) exp_q.push_back('{4'd1, 2'd1, 2'd2, 0});
    for (int i = 0; i < 15; i++) begin
      cam_pulse(3'b010, 1'b1, 2'd1);
      tick(29);
    end
    checks++;
    if (obs_q.size() != 3) begin
      failures++; $display("FAIL resend_count: got %0d requests expected 3", obs_q.size());
    end else begin
      d1 = obs_q[1].t - obs_q[0].t;
      d2 = obs_q[2].t - obs_q[0].t;
      checks++;
      if (d1 < 195 || d1 > 215 || d2 < 395 || d2 > 425) begin
        failures++; $display("FAIL resend_timing: got %0d/%0d cycles expected ~200/~400", d1, d2);
      end
      for (int i = 0; i < 3; i++) begin
        rec_t e, o;
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++;
        if ({o.cmd, o.spd} !== {e.cmd, e.spd}) begin
          failures++; $display("FAIL resend_cmd[%0d]: got cmd=%0d spd=%0d expected cmd=%0d spd=%0d", i, o.cmd, o.spd, e.cmd, e.spd);
        end
      end
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    int trise;
    do_reset();
    ack_en = 1'b0;
    ir_pulse(4'd1, 2'd0);
    wait_obs(1, 10, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL wdog_first_req: got 0 requests expected 1");
    end else begin
      trise = obs_q[0].t;
`ifdef DRIVE_SCHED_WATCHDOG_EN
      begin
        int k = 0;
        while (tx_req && k < 40) begin tick(1); k++; end
      end
      checks++;
      if (tx_req !== 1'b0 || (cyc - trise) < 18 || (cyc - trise) > 22) begin
        failures++; $display("FAIL wdog_drop: got tx_req=%b after %0d cycles expected 0 after ~20", tx_req, cyc - trise);
      end
      tick(2);
      checks++;
      if (terr_cnt != 1) begin failures++; $display("FAIL wdog_pulse: got %0d pulses expected 1", terr_cnt); end
      wait_obs(2, 10, ok);
      checks++;
      if (!ok || obs_q[1].cmd !== 4'd1) begin
        failures++; $display("FAIL wdog_resend: got %0d requests expected re-send of cmd 1", obs_q.size());
      end
      ack_en = 1'b1;
      tick(5);
`else
      tick(40);
      checks++;
      if (tx_req !== 1'b1 || terr_cnt != 0) begin
        failures++; $display("FAIL wait_forever: got tx_req=%b pulses=%0d expected 1/0", tx_req, terr_cnt);
      end
      ack_en = 1'b1;
      tick(5);
      checks++;
      if (tx_req !== 1'b0) begin failures++; $display("FAIL late_ack: got %b expected 0", tx_req); end
`endif
    end
  endtask

  task automatic test_reset_wait_ack();
    bit ok;
    do_reset();
    ack_en = 1'b0;
    ir_pulse(4'd2, 2'd1);
    wait_obs(1, 10, ok);
    tick(2);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (!ok || tx_req !== 1'b0) begin failures++; $display("FAIL reset_async_drop: got %b expected 0", tx_req); end
    tick(2);
    reset = 1'b0;
    tick(1);
    manual_ack = 1'b1;
    tick(1);
    manual_ack = 1'b0;
    tick(5);
    checks++;
    if (tx_req !== 1'b0 || tx_cmd !== 4'd0 || source !== 2'd0) begin
      failures++; $display("FAIL reset_after_release: got req=%b cmd=%0d src=%0d expected 0/0/0", tx_req, tx_cmd, source);
    end
    checks++;
    if (obs_q.size() != 1) begin failures++; $display("FAIL reset_ack_ignored: got %0d requests expected 1", obs_q.size()); end
    ack_en = 1'b1;
  endtask

  initial begin
    reset = 1'b1; ir_valid = 0; cam_valid = 0; ir_cmd = 0; cam_direction = 0;
    orange_detected = 0; speed = 0; tx_ack = 0;
    test_reset();
    test_ir_latency();
    test_hold();
    test_same_cycle();
    test_cam_map();
    test_resend();
    test_watchdog();
    test_reset_wait_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish within bound");
    $fatal(1, "timeout");
  end

endmodule
